// File: rtl/ddr_rd_master.sv
// AXI4 read master: turns one start command into a single INCR burst of 64-bit beats,
// streams the returned data out and keeps beat/latency/error statistics.
module ddr_rd_master #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 64,
    parameter int MAX_LEN = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RSTART_REG,
    input  logic [31:0]       RADDR_REG,
    input  logic [31:0]       RLENGTH_REG,
    output logic              RIDLE_REG,
    output logic              RERR_REG,
    output logic [31:0]       RBEATS_REG,
    output logic [31:0]       RCYCLES_REG,
    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic [7:0]        m_axi_arlen,
    output logic [2:0]        m_axi_arsize,
    output logic [1:0]        m_axi_arburst,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    input  logic [DATA_W-1:0] m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rlast,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tlast,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready
);

    localparam logic [9:0] MaxLen = 10'(MAX_LEN);
    localparam logic [2:0] ArSize = 3'($clog2(DATA_W / 8));

    typedef enum logic [1:0] {
        IDLE,
        AR,
        DATA
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic [7:0]        arlen_q, arlen_d;
    logic [7:0]        beatCnt_q, beatCnt_d;
    logic [31:0]       cycCnt_q, cycCnt_d;
    logic [31:0]       rBeats_q, rBeats_d;
    logic [31:0]       rCycles_q, rCycles_d;
    logic              err_q, err_d;

    logic [8:0]        cmdLen;
    logic [ADDR_W-1:0] alignedAddr;
    logic [13:0]       endOffset;
    logic              lenZero;
    logic              lenBad;
    logic              beatFire;
    logic              lastBeat;
    logic              unusedBits;

    assign cmdLen      = RLENGTH_REG[8:0];
    assign alignedAddr = {RADDR_REG[ADDR_W-1:3], 3'b000};
    assign unusedBits  = ^{RLENGTH_REG[31:9], RADDR_REG[2:0]};

    // A burst may end exactly on a 4 KB boundary but must not run past it.
    assign endOffset = {2'b00, alignedAddr[11:0]} + {2'b00, cmdLen, 3'b000};
    assign lenZero   = (cmdLen == 9'd0);
    assign lenBad    = ({1'b0, cmdLen} > MaxLen) || (endOffset > 14'd4096);

    assign beatFire  = (state_q == DATA) && m_axi_rvalid && m_axis_tready;
    assign lastBeat  = (beatCnt_q == arlen_q);

    always_comb begin
        state_d   = state_q;
        araddr_d  = araddr_q;
        arlen_d   = arlen_q;
        beatCnt_d = beatCnt_q;
        cycCnt_d  = cycCnt_q;
        rBeats_d  = rBeats_q;
        rCycles_d = rCycles_q;
        err_d     = err_q;
        case (state_q)
            IDLE: begin
                if (RSTART_REG && !lenZero) begin
                    if (lenBad) begin
                        err_d = 1'b1;
                    end else begin
                        araddr_d  = alignedAddr;
                        arlen_d   = 8'(cmdLen - 9'd1);
                        beatCnt_d = '0;
                        cycCnt_d  = '0;
                        state_d   = AR;
                    end
                end
            end
            AR: begin
                cycCnt_d = cycCnt_q + 32'd1;
                if (m_axi_arready) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                cycCnt_d = cycCnt_q + 32'd1;
                if (beatFire) begin
                    beatCnt_d = beatCnt_q + 8'd1;
                    rBeats_d  = rBeats_q + 32'd1;
                    if (m_axi_rresp != 2'b00 || m_axi_rlast != lastBeat) begin
                        err_d = 1'b1;
                    end
                    // Latency also covers the accept cycle and the final beat cycle.
                    if (lastBeat) begin
                        rCycles_d = cycCnt_q + 32'd2;
                        state_d   = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            araddr_q  <= '0;
            arlen_q   <= '0;
            beatCnt_q <= '0;
            cycCnt_q  <= '0;
            rBeats_q  <= '0;
            rCycles_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            araddr_q  <= araddr_d;
            arlen_q   <= arlen_d;
            beatCnt_q <= beatCnt_d;
            cycCnt_q  <= cycCnt_d;
            rBeats_q  <= rBeats_d;
            rCycles_q <= rCycles_d;
            err_q     <= err_d;
        end
    end

    assign RIDLE_REG     = (state_q == IDLE);
    assign RERR_REG      = err_q;
    assign RBEATS_REG    = rBeats_q;
    assign RCYCLES_REG   = rCycles_q;

    assign m_axi_araddr  = araddr_q;
    assign m_axi_arlen   = arlen_q;
    assign m_axi_arsize  = ArSize;
    assign m_axi_arburst = 2'b01;
    assign m_axi_arvalid = (state_q == AR);

    // R channel is wired straight through to the stream only while a burst is active.
    assign m_axi_rready  = (state_q == DATA) && m_axis_tready;
    assign m_axis_tvalid = (state_q == DATA) && m_axi_rvalid;
    assign m_axis_tdata  = m_axi_rdata;
    assign m_axis_tlast  = (state_q == DATA) && lastBeat;

endmodule

// File: tb/tb_ddr_rd_master.sv
// Directed and randomized bench for ddr_rd_master, checked against a command-level
// model of expected bursts, stream beats and statistics.
module tb_ddr_rd_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        RSTART_REG;
    logic [31:0] RADDR_REG;
    logic [31:0] RLENGTH_REG;
    logic        RIDLE_REG;
    logic        RERR_REG;
    logic [31:0] RBEATS_REG;
    logic [31:0] RCYCLES_REG;
    logic [31:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic        m_axi_arvalid;
    logic        m_axi_arready;
    logic [63:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rlast;
    logic        m_axi_rvalid;
    logic        m_axi_rready;
    logic [63:0] m_axis_tdata;
    logic        m_axis_tlast;
    logic        m_axis_tvalid;
    logic        m_axis_tready;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] modelBeats;
    logic [31:0] modelCycles;
    logic        modelErr;

    ddr_rd_master dut (
        .clk           (clk),
        .rst           (rst),
        .RSTART_REG    (RSTART_REG),
        .RADDR_REG     (RADDR_REG),
        .RLENGTH_REG   (RLENGTH_REG),
        .RIDLE_REG     (RIDLE_REG),
        .RERR_REG      (RERR_REG),
        .RBEATS_REG    (RBEATS_REG),
        .RCYCLES_REG   (RCYCLES_REG),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arlen   (m_axi_arlen),
        .m_axi_arsize  (m_axi_arsize),
        .m_axi_arburst (m_axi_arburst),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rlast   (m_axi_rlast),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic reportTimeout(input string tag);
        checks++;
        failures++;
        $display("[TB] FAIL %s observed=no-handshake expected=handshake", tag);
    endtask

    task automatic idleInputs();
        RSTART_REG    = 1'b0;
        m_axi_arready = 1'b0;
        m_axi_rvalid  = 1'b0;
        m_axi_rresp   = 2'b00;
        m_axi_rlast   = 1'b0;
        m_axi_rdata   = '0;
        m_axis_tready = 1'b0;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        idleInputs();
        repeat (2) @(negedge clk);
        rst         = 1'b0;
        modelBeats  = '0;
        modelCycles = '0;
        modelErr    = 1'b0;
    endtask

    task automatic checkStats(input string tag);
        checkOutput({tag, "_idle"},   64'(RIDLE_REG),   64'(1'b1));
        checkOutput({tag, "_beats"},  64'(RBEATS_REG),  64'(modelBeats));
        checkOutput({tag, "_cycles"}, 64'(RCYCLES_REG), 64'(modelCycles));
        checkOutput({tag, "_err"},    64'(RERR_REG),    64'(modelErr));
    endtask

    // hsMode: 0 = rvalid/tready always high, 1 = tready toggles 1/0, 2 = both random.
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] rlen, input int arDelay,
                                 input int hsMode, input int respErrBeat, input int lastErrBeat);
        int          len;
        int          cyc;
        int          idx;
        bit          arDone;
        bit          valid;
        bit          fire;
        logic [31:0] expAddr;
        logic [63:0] beatData[256];

        len     = int'(rlen[8:0]);
        expAddr = addr & 32'hFFFF_FFF8;
        valid   = (len != 0) && (len <= 16) && (int'(addr[11:0] & 12'hFF8) + len * 8 <= 4096);
        for (int i = 0; i < len; i++) beatData[i] = {$urandom, $urandom};

        @(negedge clk);
        RSTART_REG  = 1'b1;
        RADDR_REG   = addr;
        RLENGTH_REG = rlen;
        #1;
        checkOutput("start_idle",    64'(RIDLE_REG),     64'(1'b1));
        checkOutput("start_arvalid", 64'(m_axi_arvalid), 64'(1'b0));

        if (!valid) begin
            if (len != 0) modelErr = 1'b1;
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                RSTART_REG = 1'b0;
                #1;
                checkOutput("rej_arvalid", 64'(m_axi_arvalid), 64'(1'b0));
                checkOutput("rej_idle",    64'(RIDLE_REG),     64'(1'b1));
            end
            checkStats("rej");
            return;
        end

        cyc    = 0;
        arDone = 1'b0;
        for (int i = 0; i <= arDelay + 20 && !arDone; i++) begin
            @(negedge clk);
            RSTART_REG    = 1'b0;
            m_axi_arready = (i >= arDelay);
            cyc++;
            #1;
            checkOutput("ar_arvalid", 64'(m_axi_arvalid), 64'(1'b1));
            checkOutput("ar_araddr",  64'(m_axi_araddr),  64'(expAddr));
            checkOutput("ar_arlen",   64'(m_axi_arlen),   64'(len - 1));
            checkOutput("ar_ridle",   64'(RIDLE_REG),     64'(1'b0));
            if (m_axi_arready && m_axi_arvalid) arDone = 1'b1;
        end
        if (!arDone) begin
            reportTimeout("ar_timeout");
            return;
        end

        idx = 0;
        for (int i = 0; i < 2000 && idx < len; i++) begin
            @(negedge clk);
            m_axi_arready = 1'b0;
            cyc++;
            case (hsMode)
                0: begin
                    m_axi_rvalid  = 1'b1;
                    m_axis_tready = 1'b1;
                end
                1: begin
                    m_axi_rvalid  = 1'b1;
                    m_axis_tready = (i % 2 == 0);
                end
                default: begin
                    m_axi_rvalid  = ($urandom_range(0, 3) != 0);
                    m_axis_tready = ($urandom_range(0, 3) != 0);
                end
            endcase
            m_axi_rdata = beatData[idx];
            m_axi_rresp = (idx == respErrBeat) ? 2'b10 : 2'b00;
            m_axi_rlast = (idx == len - 1) ^ (idx == lastErrBeat);
            #1;
            checkOutput("d_tvalid", 64'(m_axis_tvalid), 64'(m_axi_rvalid));
            checkOutput("d_rready", 64'(m_axi_rready),  64'(m_axis_tready));
            fire = m_axi_rvalid && m_axis_tready;
            if (m_axi_rvalid) begin
                checkOutput("d_tdata", m_axis_tdata,       beatData[idx]);
                checkOutput("d_tlast", 64'(m_axis_tlast),  64'(idx == len - 1));
            end
            if (fire) begin
                if (idx == respErrBeat || idx == lastErrBeat) modelErr = 1'b1;
                modelBeats = modelBeats + 32'd1;
                idx++;
            end
        end
        if (idx < len) begin
            reportTimeout("data_timeout");
            return;
        end
        modelCycles = 32'(cyc + 1);

        @(negedge clk);
        m_axi_rvalid  = 1'b0;
        m_axis_tready = 1'b0;
        m_axi_rlast   = 1'b0;
        m_axi_rresp   = 2'b00;
        #1;
        checkStats("done");
        checkOutput("done_arvalid", 64'(m_axi_arvalid), 64'(1'b0));
    endtask

    initial begin
        logic [31:0] rAddr;
        logic [31:0] rLen;

        rst         = 1'b1;
        RADDR_REG   = '0;
        RLENGTH_REG = '0;
        idleInputs();
        repeat (3) @(negedge clk);
        #1;
        checkOutput("rst_idle",    64'(RIDLE_REG),     64'(1'b1));
        checkOutput("rst_err",     64'(RERR_REG),      64'(1'b0));
        checkOutput("rst_beats",   64'(RBEATS_REG),    64'(0));
        checkOutput("rst_cycles",  64'(RCYCLES_REG),   64'(0));
        checkOutput("rst_arvalid", 64'(m_axi_arvalid), 64'(1'b0));
        checkOutput("rst_araddr",  64'(m_axi_araddr),  64'(0));
        checkOutput("rst_arlen",   64'(m_axi_arlen),   64'(0));
        checkOutput("rst_arsize",  64'(m_axi_arsize),  64'(3'b011));
        checkOutput("rst_arburst", 64'(m_axi_arburst), 64'(2'b01));
        checkOutput("rst_rready",  64'(m_axi_rready),  64'(1'b0));
        rst         = 1'b0;
        modelBeats  = '0;
        modelCycles = '0;
        modelErr    = 1'b0;

        $display("[TB] basic 8-beat burst");
        applyStimulus(32'h0000_1000, 32'd8, 0, 0, -1, -1);
        checkOutput("basic_cycles10", 64'(RCYCLES_REG), 64'(10));

        $display("[TB] delayed arready, toggled tready");
        applyStimulus(32'h0000_2000, 32'd8, 5, 1, -1, -1);

        $display("[TB] boundary-exact bursts");
        applyStimulus(32'h0000_1FF0, 32'd2, 1, 2, -1, -1);
        applyStimulus(32'h0000_0F80, 32'd16, 0, 2, -1, -1);

        $display("[TB] zero length");
        applyStimulus(32'h0000_4000, 32'd0, 0, 0, -1, -1);

        $display("[TB] random commands");
        for (int n = 0; n < 8; n++) begin
            rAddr = $urandom;
            rLen  = 32'($urandom_range(1, 16)) | ({$urandom} & 32'hFFFF_FE00);
            applyStimulus(rAddr, rLen, $urandom_range(0, 3), 2, -1, -1);
        end

        $display("[TB] 4 KB crossing");
        doReset();
        applyStimulus(32'h0000_0FF8, 32'd2, 0, 0, -1, -1);

        $display("[TB] over-length");
        doReset();
        applyStimulus(32'h0000_0000, 32'd17, 0, 0, -1, -1);

        $display("[TB] bad rresp");
        doReset();
        applyStimulus(32'h0000_5000, 32'd4, 0, 0, 1, -1);

        $display("[TB] early rlast");
        doReset();
        applyStimulus(32'h0000_6000, 32'd4, 0, 0, -1, 2);

        $display("[TB] reset mid-burst");
        doReset();
        @(negedge clk);
        RSTART_REG  = 1'b1;
        RADDR_REG   = 32'h0000_7000;
        RLENGTH_REG = 32'd8;
        @(negedge clk);
        RSTART_REG    = 1'b0;
        m_axi_arready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            m_axi_arready = 1'b0;
            m_axi_rvalid  = 1'b1;
            m_axis_tready = 1'b1;
            m_axi_rdata   = {$urandom, $urandom};
            m_axi_rlast   = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        modelBeats  = '0;
        modelCycles = '0;
        modelErr    = 1'b0;
        #1;
        checkOutput("mid_idle",    64'(RIDLE_REG),     64'(1'b1));
        checkOutput("mid_arvalid", 64'(m_axi_arvalid), 64'(1'b0));
        checkOutput("mid_rready",  64'(m_axi_rready),  64'(1'b0));
        checkOutput("mid_tvalid",  64'(m_axis_tvalid), 64'(1'b0));
        checkOutput("mid_beats",   64'(RBEATS_REG),    64'(0));
        checkOutput("mid_cycles",  64'(RCYCLES_REG),   64'(0));
        @(negedge clk);
        idleInputs();
        applyStimulus(32'h0000_8000, 32'd8, 0, 0, -1, -1);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
